// File: rtl/ocx_tlx_data_sched.sv
// rtl/ocx_tlx_data_sched.sv - TLX receive data-flit scheduler; OCX_TLX_DATA_SCHED_STATS_EN adds routed-flit counters
module ocx_tlx_data_sched #(
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          i_tlx_clk,
  input  logic                          i_reset,
  input  logic                          i_sched_req_v,
  input  logic                          i_sched_req_vc,
  input  logic [1:0]                    i_sched_req_cnt,
  output logic                          o_sched_req_ready,
  input  logic                          i_pars_data_valid,
  input  logic [511:0]                  i_pars_data_flit,
  input  logic                          i_good_crc,
  input  logic                          i_crc_error,
  output logic                          o_dcp0_data_v,
  output logic                          o_dcp1_data_v,
  output logic [511:0]                  o_dcp0_data,
  output logic [511:0]                  o_dcp1_data,
  output logic                          o_sched_busy,
  output logic [$clog2(FIFO_DEPTH):0]   o_sched_entries,
  output logic                          o_sched_underrun,
`ifdef OCX_TLX_DATA_SCHED_STATS_EN
  output logic [15:0]                   o_sched_vc0_flits,
  output logic [15:0]                   o_sched_vc1_flits,
`endif
  output logic                          o_sched_overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [2:0]  r_fifo [FIFO_DEPTH];
  logic [AW:0] r_wr_spec, r_wr_cmt, r_rd_spec, r_rd_cmt;
  logic [2:0]  r_rem_spec, r_rem_cmt;
  logic        r_dcp0_v, r_dcp1_v, r_underrun, r_overflow;
  logic [511:0] r_dcp0_data, r_dcp1_data;

  logic [AW:0] w_count, w_wr_nxt, w_rd_nxt;
  logic [2:0]  w_rem_nxt, w_rem_eff, w_rem_dec, w_head;
  logic        w_ready, w_have, w_push, w_route;

  assign w_count   = r_wr_spec - r_rd_spec;
  assign w_ready   = ~w_count[AW];
  assign w_have    = (w_count != '0);
  assign w_push    = i_sched_req_v & w_ready & ~i_crc_error;
  assign w_route   = i_pars_data_valid & w_have & ~i_crc_error;
  assign w_head    = r_fifo[r_rd_spec[AW-1:0]];
  assign w_rem_eff = (r_rem_spec == 3'd0) ? ({1'b0, w_head[1:0]} + 3'd1) : r_rem_spec;
  assign w_rem_dec = w_rem_eff - 3'd1;

  always_comb begin
    w_wr_nxt  = r_wr_spec + {{AW{1'b0}}, w_push};
    w_rd_nxt  = r_rd_spec;
    w_rem_nxt = r_rem_spec;
    if (w_route) begin
      w_rem_nxt = w_rem_dec;
      if (w_rem_dec == 3'd0) w_rd_nxt = r_rd_spec + 1'b1;
    end
    if (i_crc_error) begin
      w_wr_nxt  = r_wr_cmt;
      w_rd_nxt  = r_rd_cmt;
      w_rem_nxt = r_rem_cmt;
    end
  end

  always_ff @(posedge i_tlx_clk) begin
    if (w_push) r_fifo[r_wr_spec[AW-1:0]] <= {i_sched_req_vc, i_sched_req_cnt};
  end

  always_ff @(posedge i_tlx_clk or posedge i_reset) begin
    if (i_reset) begin
      r_wr_spec   <= '0;
      r_wr_cmt    <= '0;
      r_rd_spec   <= '0;
      r_rd_cmt    <= '0;
      r_rem_spec  <= '0;
      r_rem_cmt   <= '0;
      r_dcp0_v    <= 1'b0;
      r_dcp1_v    <= 1'b0;
      r_dcp0_data <= '0;
      r_dcp1_data <= '0;
      r_underrun  <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      r_wr_spec  <= w_wr_nxt;
      r_rd_spec  <= w_rd_nxt;
      r_rem_spec <= w_rem_nxt;
      // crc_error forces the next-state to the commit point, so this is a no-op then
      if (i_good_crc) begin
        r_wr_cmt  <= w_wr_nxt;
        r_rd_cmt  <= w_rd_nxt;
        r_rem_cmt <= w_rem_nxt;
      end
      r_dcp0_v <= w_route & ~w_head[2];
      r_dcp1_v <= w_route &  w_head[2];
      if (w_route & ~w_head[2]) r_dcp0_data <= i_pars_data_flit;
      if (w_route &  w_head[2]) r_dcp1_data <= i_pars_data_flit;
      if (i_pars_data_valid & ~w_have & ~i_crc_error) r_underrun <= 1'b1;
      if (i_sched_req_v & ~w_ready) r_overflow <= 1'b1;
    end
  end

`ifdef OCX_TLX_DATA_SCHED_STATS_EN
  logic [15:0] r_vc0_flits, r_vc1_flits;

  always_ff @(posedge i_tlx_clk or posedge i_reset) begin
    if (i_reset) begin
      r_vc0_flits <= '0;
      r_vc1_flits <= '0;
    end else begin
      if (w_route & ~w_head[2] & ~&r_vc0_flits) r_vc0_flits <= r_vc0_flits + 16'd1;
      if (w_route &  w_head[2] & ~&r_vc1_flits) r_vc1_flits <= r_vc1_flits + 16'd1;
    end
  end

  assign o_sched_vc0_flits = r_vc0_flits;
  assign o_sched_vc1_flits = r_vc1_flits;
`endif

  assign o_sched_req_ready = w_ready;
  assign o_sched_entries   = w_count;
  assign o_sched_busy      = w_have | (r_rem_spec != 3'd0);
  assign o_dcp0_data_v     = r_dcp0_v;
  assign o_dcp1_data_v     = r_dcp1_v;
  assign o_dcp0_data       = r_dcp0_data;
  assign o_dcp1_data       = r_dcp1_data;
  assign o_sched_underrun  = r_underrun;
  assign o_sched_overflow  = r_overflow;

endmodule

// File: tb/tb_ocx_tlx_data_sched.sv
// tb/tb_ocx_tlx_data_sched.sv - directed self-checking bench for ocx_tlx_data_sched
module tb_ocx_tlx_data_sched;

  logic         clk = 1'b0;
  logic         rst;
  logic         req_v, req_vc;
  logic [1:0]   req_cnt;
  logic         ready;
  logic         pv;
  logic [511:0] pflit;
  logic         good_crc, crc_err;
  logic         d0_v, d1_v;
  logic [511:0] d0, d1;
  logic         busy;
  logic [3:0]   entries;
  logic         underrun, overflow;
`ifdef OCX_TLX_DATA_SCHED_STATS_EN
  logic [15:0]  vc0_flits, vc1_flits;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ocx_tlx_data_sched #(.FIFO_DEPTH(8)) dut (
    .i_tlx_clk         (clk),
    .i_reset           (rst),
    .i_sched_req_v     (req_v),
    .i_sched_req_vc    (req_vc),
    .i_sched_req_cnt   (req_cnt),
    .o_sched_req_ready (ready),
    .i_pars_data_valid (pv),
    .i_pars_data_flit  (pflit),
    .i_good_crc        (good_crc),
    .i_crc_error       (crc_err),
    .o_dcp0_data_v     (d0_v),
    .o_dcp1_data_v     (d1_v),
    .o_dcp0_data       (d0),
    .o_dcp1_data       (d1),
    .o_sched_busy      (busy),
    .o_sched_entries   (entries),
    .o_sched_underrun  (underrun),
`ifdef OCX_TLX_DATA_SCHED_STATS_EN
    .o_sched_vc0_flits (vc0_flits),
    .o_sched_vc1_flits (vc1_flits),
`endif
    .o_sched_overflow  (overflow)
  );

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [511:0] pat(input int i);
    logic [31:0] w;
    w = 32'hA5C30000 + 32'(i);
    return {16{w}};
  endfunction

  task automatic push(input logic vc, input logic [1:0] cnt);
    req_v = 1'b1; req_vc = vc; req_cnt = cnt;
    tick();
    req_v = 1'b0;
  endtask

  task automatic flit(input int i);
    pv = 1'b1; pflit = pat(i);
    tick();
    pv = 1'b0;
  endtask

  logic exp_vc [4];

  initial begin
    rst = 1'b1; req_v = 0; req_vc = 0; req_cnt = 0; pv = 0; pflit = '0;
    good_crc = 0; crc_err = 0;
    tick(); tick();
    rst = 1'b0;
    tick();

    check("rst_ready", 512'(ready), 512'd1);
    check("rst_entries", 512'(entries), 512'd0);
    check("rst_busy", 512'(busy), 512'd0);
    check("rst_d0v", 512'(d0_v), 512'd0);
    check("rst_d1v", 512'(d1_v), 512'd0);
    check("rst_d0", d0, 512'd0);
    check("rst_d1", d1, 512'd0);
    check("rst_flags", 512'({underrun, overflow}), 512'd0);

    // one vc1 entry of 4 flits
    push(1'b1, 2'd3);
    check("t1_entries", 512'(entries), 512'd1);
    check("t1_busy", 512'(busy), 512'd1);
    for (int i = 0; i < 4; i++) begin
      flit(i);
      check($sformatf("t1_d1v_%0d", i), 512'(d1_v), 512'd1);
      check($sformatf("t1_d0v_%0d", i), 512'(d0_v), 512'd0);
      check($sformatf("t1_d1_%0d", i), d1, pat(i));
      check($sformatf("t1_ent_%0d", i), 512'(entries), (i < 3) ? 512'd1 : 512'd0);
    end
    tick();
    check("t1_idle_d1v", 512'(d1_v), 512'd0);
    check("t1_hold_d1", d1, pat(3));
    check("t1_idle_busy", 512'(busy), 512'd0);

    // mixed entries
    push(1'b0, 2'd0);
    push(1'b1, 2'd1);
    push(1'b0, 2'd0);
    check("t2_entries", 512'(entries), 512'd3);
    exp_vc[0] = 0; exp_vc[1] = 1; exp_vc[2] = 1; exp_vc[3] = 0;
    for (int i = 0; i < 4; i++) begin
      flit(10 + i);
      check($sformatf("t2_d0v_%0d", i), 512'(d0_v), 512'(!exp_vc[i]));
      check($sformatf("t2_d1v_%0d", i), 512'(d1_v), 512'(exp_vc[i]));
    end
    check("t2_d0_last", d0, pat(13));
    check("t2_d1_last", d1, pat(12));
    check("t2_entries_end", 512'(entries), 512'd0);

    // commit, partial consume, rewind, replay
    good_crc = 1'b1;
    push(1'b0, 2'd3);
    good_crc = 1'b0;
    flit(20);
    flit(21);
    check("t3_d0v_pre", 512'(d0_v), 512'd1);
    crc_err = 1'b1;
    pv = 1'b1; pflit = pat(22);
    tick();
    pv = 1'b0; crc_err = 1'b0;
    check("t3_rewind_d0v", 512'(d0_v), 512'd0);
    check("t3_rewind_ent", 512'(entries), 512'd1);
    for (int i = 0; i < 4; i++) begin
      good_crc = (i == 3);
      flit(30 + i);
      check($sformatf("t3_replay_d0v_%0d", i), 512'(d0_v), 512'd1);
      check($sformatf("t3_replay_ent_%0d", i), 512'(entries), (i < 3) ? 512'd1 : 512'd0);
    end
    good_crc = 1'b0;
    check("t3_replay_d0", d0, pat(33));

    // good_crc and crc_error together: rewind wins, push discarded
    good_crc = 1'b1; crc_err = 1'b1;
    push(1'b1, 2'd0);
    good_crc = 1'b0; crc_err = 1'b0;
    check("t3b_entries", 512'(entries), 512'd0);

    // fill, overflow, one pop frees a slot
    for (int i = 0; i < 8; i++) push(1'b1, 2'd0);
    check("t4_full_ent", 512'(entries), 512'd8);
    check("t4_full_ready", 512'(ready), 512'd0);
    check("t4_no_ovf_yet", 512'(overflow), 512'd0);
    push(1'b0, 2'd0);
    check("t4_ovf", 512'(overflow), 512'd1);
    check("t4_ovf_ent", 512'(entries), 512'd8);
    flit(40);
    check("t4_pop_d1v", 512'(d1_v), 512'd1);
    check("t4_pop_ready", 512'(ready), 512'd1);
    check("t4_pop_ent", 512'(entries), 512'd7);
    for (int i = 0; i < 7; i++) flit(41 + i);
    check("t4_drain_ent", 512'(entries), 512'd0);
    check("t4_drain_d0v_none", 512'(d0_v), 512'd0);

    // underrun, including push+flit in the same cycle on empty
    check("t5_no_under_yet", 512'(underrun), 512'd0);
    flit(50);
    check("t5_d0v", 512'(d0_v), 512'd0);
    check("t5_d1v", 512'(d1_v), 512'd0);
    check("t5_under", 512'(underrun), 512'd1);
    req_v = 1'b1; req_vc = 1'b0; req_cnt = 2'd0; pv = 1'b1; pflit = pat(51);
    tick();
    req_v = 1'b0; pv = 1'b0;
    check("t5_bypass_d0v", 512'(d0_v), 512'd0);
    check("t5_bypass_ent", 512'(entries), 512'd1);
    flit(52);
    check("t5_after_d0v", 512'(d0_v), 512'd1);
    check("t5_after_d0", d0, pat(52));
    tick(); tick();
    check("t5_sticky", 512'({underrun, overflow}), 512'b11);

    // asynchronous reset mid-run
    push(1'b1, 2'd2);
    flit(60);
    #2 rst = 1'b1;
    #1;
    check("t6_rst_ent", 512'(entries), 512'd0);
    check("t6_rst_ready", 512'(ready), 512'd1);
    check("t6_rst_flags", 512'({underrun, overflow}), 512'd0);
    check("t6_rst_d1", d1, 512'd0);
    check("t6_rst_d1v", 512'(d1_v), 512'd0);
    tick();
    rst = 1'b0;
    tick();
    check("t6_release_d1v", 512'(d1_v), 512'd0);
    check("t6_release_busy", 512'(busy), 512'd0);

`ifdef OCX_TLX_DATA_SCHED_STATS_EN
    check("t7_vc0_init", 512'(vc0_flits), 512'd0);
    push(1'b1, 2'd0);
    flit(70);
    check("t7_vc1_one", 512'(vc1_flits), 512'd1);
    // push and flit each cycle: every flit after the first consumes last cycle's entry
    req_vc = 1'b0; req_cnt = 2'd0;
    for (int i = 0; i < 70000; i++) begin
      req_v = 1'b1; pv = 1'b1; pflit = pat(i);
      tick();
    end
    req_v = 1'b0; pv = 1'b0;
    check("t7_vc0_sat", 512'(vc0_flits), 512'hFFFF);
    check("t7_vc1_keep", 512'(vc1_flits), 512'd1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ocx_tlx_data_sched.md
# ocx_tlx_data_sched

Receive-side data-flit scheduler for the TLX parse path. It sits between the control FSM and the data arbiter. It queues data-ownership entries (VC plus flit count) that the control FSM posts while it decodes control flits. It then steers each data flit coming out of the flit parser to the VC0 (response/dcp0) or VC1 (command/dcp1) data port, in entry order. On a CRC error it rewinds all uncommitted state so the replayed run is steered identically.

## Interface
- FIFO_DEPTH, 8, entry FIFO depth; power of two, 4..32.
- tlx_clk  in  1  clock; all logic rising-edge.
- reset  in  1  asynchronous, active-high reset.
- sched_req_v  in  1  post one ownership entry this cycle.
- sched_req_vc  in  1  0 = VC0/dcp0, 1 = VC1/dcp1.
- sched_req_cnt  in  2  flit count minus one (0..3 → 1..4 flits).
- sched_req_ready  out  1  FIFO not full (speculative count < FIFO_DEPTH).
- pars_data_valid  in  1  data flit present on pars_data_flit.
- pars_data_flit  in  512  data flit payload.
- good_crc  in  1  current run CRC good; commit.
- crc_error  in  1  current run CRC bad; rewind to last commit.
- dcp0_data_v / dcp1_data_v  out  1 each  routed-flit strobe.
- dcp0_data / dcp1_data  out  512 each  routed payload; holds last value when not strobed.
- sched_busy  out  1  speculative entry count ≠ 0 or a partially consumed entry exists.
- sched_entries  out  $clog2(FIFO_DEPTH)+1  speculative occupancy.
- sched_underrun  out  1  sticky: data flit arrived with no entry.
- sched_overflow  out  1  sticky: sched_req_v while sched_req_ready = 0.

## Operation
- State: write pointer wr_spec/wr_cmt; read pointer rd_spec/rd_cmt; remaining-flit counter rem_spec/rem_cmt (3 bits, 0 = head entry not yet started).
- Push: when sched_req_v && ready, store {vc, cnt} at wr_spec, then wr_spec++ (wraps modulo FIFO_DEPTH).
- Overflow: on sched_req_v && !ready, drop the entry and set sched_overflow.
- Data flit with occupancy > 0: route it to the head entry's VC.
  - If rem_spec = 0, load rem_spec = cnt+1, then decrement for this flit.
  - When rem_spec reaches 0, pop: rd_spec++.
- Data flit with occupancy = 0: drop the flit, assert no strobe, set sched_underrun.
- No same-cycle bypass: a push and a data flit in the same cycle on an empty FIFO is an underrun.
- good_crc: spec state (including the effect of this cycle's push/flit) → cmt.
- crc_error: all spec state ← cmt. This cycle's push and flit are discarded. No strobe is issued.
- good_crc && crc_error together: crc_error wins.
- Sticky flags clear only on reset.

## Timing
- Reset: all pointers and counters 0, sched_req_ready = 1, every other output 0, including both data buses.
- Latency: pars_data_valid at cycle N → dcpX_data_v and dcpX_data registered at N+1. At most one strobe per cycle.
- A push at N is steerable by a flit at N+1 or later.
- A pop at N frees its slot; sched_req_ready reflects it at N+1.
- sched_entries counts a partially consumed head entry until its last flit.
- Reset asserted mid-run: state clears immediately (asynchronous); no strobe is issued in the reset-release cycle.

## Configuration
- OCX_TLX_DATA_SCHED_STATS_EN defined: adds outputs sched_vc0_flits and sched_vc1_flits (16 bits each). These are saturating counts of routed flits. Counts increment at strobe time and are not rewound on crc_error. They reset to 0.
- Undefined: those ports and counters are absent. All other behaviour is identical.

## Test plan
- Push {vc1, cnt 3}, then 4 data flits on consecutive cycles → dcp1_data_v for 4 cycles with matching payloads, no dcp0 strobe; sched_entries 1→0 after the 4th flit.
- Push {vc0,0}, {vc1,1}, {vc0,0}, then 4 flits → strobe sequence dcp0, dcp1, dcp1, dcp0.
- Push {vc0,3}, good_crc, deliver 2 flits, assert crc_error → occupancy 1 and rem reset. Replay 4 flits → 4 dcp0 strobes.
- Fill 8 entries (FIFO_DEPTH = 8) → ready = 0. A 9th push → sched_overflow = 1 and sched_entries stays 8. One pop → ready = 1 next cycle.
- Data flit with FIFO empty → no strobe, sched_underrun = 1, stays set until reset.
- With OCX_TLX_DATA_SCHED_STATS_EN: route 70000 vc0 flits → sched_vc0_flits = 16'hFFFF.
